// File: rtl/conv1d_weight_loader.sv
// Six-lane weight loader: streams RAM_Depth*6 words into per-lane RAMs
// (lane-major within each row) and exposes one row of all lanes on a negedge read port.
module conv1d_weight_loader #(
    parameter int Bit_width = 16,
    parameter int RAM_Depth = 8
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        Start,
    input  logic                        in_valid,
    input  logic signed [Bit_width-1:0] in_data,
    output logic                        in_ready,
    output logic                        Busy,
    output logic                        Load_done,
    output logic [5:0]                  Word_count,
    input  logic                        Enable,
    input  logic [4:0]                  Depth,
    output logic signed [Bit_width-1:0] data_out_0,
    output logic signed [Bit_width-1:0] data_out_1,
    output logic signed [Bit_width-1:0] data_out_2,
    output logic signed [Bit_width-1:0] data_out_3,
    output logic signed [Bit_width-1:0] data_out_4,
    output logic signed [Bit_width-1:0] data_out_5
);

    localparam int              LANES       = 6;
    localparam int              AW          = (RAM_Depth > 1) ? $clog2(RAM_Depth) : 1;
    localparam logic [5:0]      TOTAL_WORDS = 6'(RAM_Depth * LANES);
    localparam logic [AW-1:0]   LAST_ROW    = AW'(RAM_Depth - 1);
    localparam logic [2:0]      LAST_LANE   = 3'(LANES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                      r_state;
    state_t                      w_state_next;
    logic [2:0]                  r_lane;
    logic [AW-1:0]               r_row;
    logic [5:0]                  r_word_count;
    logic                        w_accept;
    logic                        w_start_load;
    logic                        w_last_word;
    logic                        w_rd_en;
    logic [AW-1:0]               w_rd_addr;
    logic signed [Bit_width-1:0] w_lane_out [LANES];

    assign w_accept     = in_valid && (r_state == LOAD);
    assign w_start_load = Start && (r_state != LOAD);
    assign w_last_word  = w_accept && (r_lane == LAST_LANE) && (r_row == LAST_ROW);
    assign w_rd_en      = Enable && (int'(Depth) < RAM_Depth);
    assign w_rd_addr    = Depth[AW-1:0];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Start is only honoured outside LOAD, so a running load cannot be restarted.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (Start) w_state_next = LOAD;
            LOAD:    if (w_last_word) w_state_next = DONE;
            DONE:    if (Start) w_state_next = LOAD;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_lane       <= '0;
            r_row        <= '0;
            r_word_count <= '0;
        end else if (w_start_load) begin
            r_lane       <= '0;
            r_row        <= '0;
            r_word_count <= '0;
        end else if (w_accept) begin
            if (r_lane == LAST_LANE) begin
                r_lane <= '0;
                r_row  <= r_row + 1'b1;
            end else begin
                r_lane <= r_lane + 3'd1;
            end
            if (r_word_count != TOTAL_WORDS) begin
                r_word_count <= r_word_count + 6'd1;
            end
        end
    end

    // RAM contents are deliberately not reset; only the read register clears.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic signed [Bit_width-1:0] r_mem [RAM_Depth];
        logic signed [Bit_width-1:0] r_rd_data;

        always_ff @(posedge CLK) begin
            if (w_accept && (r_lane == 3'(gi))) begin
                r_mem[r_row] <= in_data;
            end
        end

        always_ff @(negedge CLK or posedge RST) begin
            if (RST) begin
                r_rd_data <= '0;
            end else if (w_rd_en) begin
                r_rd_data <= r_mem[w_rd_addr];
            end else begin
                r_rd_data <= '0;
            end
        end

        assign w_lane_out[gi] = r_rd_data;
    end

    assign in_ready   = (r_state == LOAD);
    assign Busy       = (r_state == LOAD);
    assign Load_done  = (r_state == DONE);
    assign Word_count = r_word_count;
    assign data_out_0 = w_lane_out[0];
    assign data_out_1 = w_lane_out[1];
    assign data_out_2 = w_lane_out[2];
    assign data_out_3 = w_lane_out[3];
    assign data_out_4 = w_lane_out[4];
    assign data_out_5 = w_lane_out[5];

endmodule

// File: tb/tb_conv1d_weight_loader.sv
// Directed bench for conv1d_weight_loader: full loads, stalls, ignored Start,
// mid-load reset and read-port boundaries, all against hand-computed values.
module tb_conv1d_weight_loader;

    logic               CLK;
    logic               RST;
    logic               Start;
    logic               in_valid;
    logic signed [15:0] in_data;
    logic               in_ready;
    logic               Busy;
    logic               Load_done;
    logic [5:0]         Word_count;
    logic               Enable;
    logic [4:0]         Depth;
    logic signed [15:0] dout [6];

    int checks = 0;
    int errors = 0;

    conv1d_weight_loader #(
        .Bit_width (16),
        .RAM_Depth (8)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .Start      (Start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .Busy       (Busy),
        .Load_done  (Load_done),
        .Word_count (Word_count),
        .Enable     (Enable),
        .Depth      (Depth),
        .data_out_0 (dout[0]),
        .data_out_1 (dout[1]),
        .data_out_2 (dout[2]),
        .data_out_3 (dout[3]),
        .data_out_4 (dout[4]),
        .data_out_5 (dout[5])
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end else begin
            $display("ok   %s = %0d", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Reads one row and expects lane n to hold base + n*step.
    task automatic rd_row(input string tag, input int row, input logic en,
                          input int base, input int step);
        Enable = en;
        Depth  = 5'(row);
        @(negedge CLK);
        #1;
        for (int n = 0; n < 6; n++) begin
            check($sformatf("%s_l%0d", tag, n), dout[n], base + n * step);
        end
    endtask

    initial begin
        RST      = 1'b0;
        Start    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        Enable   = 1'b1;
        Depth    = 5'd0;

        // Reset state
        #1 RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_ready", in_ready, 0);
        check("rst_busy", Busy, 0);
        check("rst_done", Load_done, 0);
        check("rst_wc", Word_count, 0);
        check("rst_dout0", dout[0], 0);
        RST = 1'b0;
        tick();
        check("idle_busy", Busy, 0);

        // Full load, valid every cycle, values k-24
        Start = 1'b1;
        tick();
        Start = 1'b0;
        check("ld1_busy", Busy, 1);
        check("ld1_ready", in_ready, 1);
        check("ld1_wc0", Word_count, 0);
        for (int k = 0; k < 48; k++) begin
            in_valid = 1'b1;
            in_data  = 16'(k - 24);
            tick();
            if (k == 46) begin
                check("ld1_done47", Load_done, 0);
                check("ld1_wc47", Word_count, 47);
            end
        end
        in_valid = 1'b0;
        check("ld1_done", Load_done, 1);
        check("ld1_busy_end", Busy, 0);
        check("ld1_ready_end", in_ready, 0);
        check("ld1_wc48", Word_count, 48);
        rd_row("ld1_d2", 2, 1'b1, -12, 1);
        rd_row("ld1_d7", 7, 1'b1, 18, 1);
        rd_row("en0", 2, 1'b0, 0, 0);
        rd_row("d8", 8, 1'b1, 0, 0);
        rd_row("d31", 31, 1'b1, 0, 0);

        // Restart from DONE, in_valid toggling every cycle
        Start = 1'b1;
        tick();
        Start = 1'b0;
        check("tg_done_drop", Load_done, 0);
        check("tg_busy", Busy, 1);
        for (int c = 0; c < 96; c++) begin
            in_valid = (c % 2 == 0);
            in_data  = 16'(c / 2 - 24);
            tick();
            if (c == 10) check("tg_wc_valid", Word_count, 6);
            if (c == 11) check("tg_wc_stall", Word_count, 6);
        end
        in_valid = 1'b0;
        check("tg_done", Load_done, 1);
        check("tg_wc48", Word_count, 48);
        rd_row("tg_d2", 2, 1'b1, -12, 1);

        // New set 1000+k, Start pulsed at word 20, same-row read-after-write
        Start = 1'b1;
        tick();
        Start  = 1'b0;
        Enable = 1'b1;
        Depth  = 5'd1;
        for (int k = 0; k < 48; k++) begin
            in_valid = 1'b1;
            in_data  = 16'(1000 + k);
            Start    = (k == 20);
            tick();
            Start = 1'b0;
            if (k == 9) begin
                @(negedge CLK);
                #1;
                check("raw_d1_l3", dout[3], 1009);
            end
            if (k == 20) begin
                check("st_ign_wc", Word_count, 21);
                check("st_ign_busy", Busy, 1);
            end
        end
        in_valid = 1'b0;
        check("new_done", Load_done, 1);
        check("new_wc48", Word_count, 48);
        rd_row("new_d0", 0, 1'b1, 1000, 1);
        rd_row("new_d3", 3, 1'b1, 1018, 1);

        // Reset after 10 words of 2000+k
        Start = 1'b1;
        tick();
        Start = 1'b0;
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1;
            in_data  = 16'(2000 + k);
            tick();
        end
        in_valid = 1'b0;
        Enable   = 1'b1;
        Depth    = 5'd0;
        @(negedge CLK);
        #1;
        check("pre_rst_d0", dout[0], 2000);
        #2 RST = 1'b1;
        #1;
        check("mid_rst_ready", in_ready, 0);
        check("mid_rst_busy", Busy, 0);
        check("mid_rst_wc", Word_count, 0);
        check("mid_rst_dout0", dout[0], 0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        tick();
        check("post_rst_busy", Busy, 0);
        Depth = 5'd1;
        @(negedge CLK);
        #1;
        check("keep_d1_l0", dout[0], 2006);
        check("keep_d1_l3", dout[3], 2009);
        check("keep_d1_l4", dout[4], 1010);

        // Reload with 0x7FFF everywhere
        Start = 1'b1;
        tick();
        Start = 1'b0;
        for (int k = 0; k < 48; k++) begin
            in_valid = 1'b1;
            in_data  = 16'sh7FFF;
            tick();
        end
        in_valid = 1'b0;
        check("max_done", Load_done, 1);
        rd_row("max_d7", 7, 1'b1, 32767, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
